mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares the single-port, byte-addressed, word-wide data memory between two requesters:
//   port 0 (instruction fetch) and port 1 (load/store).
//   Round-robin grant, one access in flight at a time, fixed 3-cycle request-to-ack latency.
//   Checks alignment and range; a failing request is answered with an error and never reaches the memory.
// PARAMETERS
//   DATA_W     32   word width; the memory stores DATA_W/8 bytes per word, little-endian
//   ADDR_W     32   byte-address width on all ports
//   MEM_BYTES  256  memory size in bytes; the legal word addresses are 0 .. MEM_BYTES-4
// PORTS
//   clk         in   1       single clock; everything samples on its posedge
//   rst_n       in   1       synchronous reset, active-low
//   p0_req      in   1       port 0 request; held with p0_we/addr/wdata until p0_ack
//   p0_we       in   1       1 = write, 0 = read
//   p0_addr     in   ADDR_W  byte address
//   p0_wdata    in   DATA_W  write data
//   p0_rdata    out  DATA_W  read data, valid in the p0_ack cycle
//   p0_ack      out  1       one-cycle completion pulse
//   p0_err      out  1       qualifies p0_ack: misaligned or out-of-range request
//   p1_*        --   --      same set as p0_*, for port 1
//   mem_addr    out  ADDR_W  memory byte address
//   mem_wdata   out  DATA_W  memory write data
//   mem_ren     out  1       memory read enable
//   mem_wen     out  1       memory write enable
//   mem_rdata   in   DATA_W  memory read data; registered, valid one cycle after the sampling edge
// BEHAVIOUR
//   Reset (rst_n=0 at posedge):
//   - state=IDLE, rr pointer favours p0.
//   - All outputs are 0, including rdata/ack/err and all mem_* signals.
//   FSM IDLE -> ISSUE -> RESP -> IDLE:
//   - IDLE: sample p0_req/p1_req at edge E0. If neither is high, stay in IDLE.
//     Otherwise grant one port, register its addr/wdata/we and go to ISSUE.
//   - ISSUE: after E0, mem_addr and mem_wdata are driven. Exactly one of mem_ren/mem_wen is 1,
//     or neither is 1 if the request is illegal. The memory acts at E1; go to RESP.
//   - RESP: at E2, capture mem_rdata into the granted port's rdata (0 for writes and errors).
//     Pulse that port's ack (and err if illegal) for the cycle after E2. Go to IDLE.
//   - After E2, mem_ren and mem_wen return to 0. mem_addr and mem_wdata hold their last values.
//   Latency and throughput:
//   - Request sampled at E0 gives ack in the cycle after E2.
//   - Maximum throughput is one access per 3 cycles.
//   Arbitration:
//   - Only one requester: it wins.
//   - Both requesting: the port not granted last wins; the pointer updates only on a grant.
//   - The loser's req stays pending. It wins at the next IDLE sample, so it waits at most one access.
//   Handshake:
//   - A requester keeps req/we/addr/wdata stable until ack. The arbiter samples them only at E0.
//   - req still high during the ack cycle counts as a new back-to-back request, sampled at the next edge.
//   - Dropping req before ack is illegal; the behaviour is undefined and is an assertion in the bench.
//   Legality:
//   - Illegal if addr[1:0]!=0 or addr > MEM_BYTES-4.
//   - An illegal request takes the same 3-cycle path, with mem_ren=mem_wen=0, rdata=0 and err=1.
//   - The memory is untouched.
//   Reset mid-operation:
//   - Abort immediately: state=IDLE, all outputs 0, no ack.
//   - A write already issued at E1 stays in memory.
//   p0_ack and p1_ack are never high in the same cycle. mem_ren and mem_wen are never both 1.
// STRUCTURE
//   mem_arb_pkg:
//   - state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2)
//   - port ids (PORT_IF=1'b0, PORT_LS=1'b1)
//   - legality function is_legal(addr)
//   Sub-module rr_arb2:
//   - 2-way round-robin arbiter: req[1:0] in, gnt[1:0] out, update input, one-hot grant, last-grant flop.
//   - Top level holds the FSM, request-capture registers, memory drive and response demux.
// TESTING
//   1. Reset, then p0 reads 0x10 holding 0xDEADBEEF -> mem_ren=1 one cycle; p0_ack=1 with p0_rdata=0xDEADBEEF 3 cycles after req.
//   2. p1 writes 0xCAFEF00D to 0x20, then p0 reads 0x20 -> mem bytes[0x20..0x23]=0D,F0,FE,CA; p0_rdata=0xCAFEF00D.
//   3. p0_req and p1_req held high together for 4 accesses -> grants alternate p0,p1,p0,p1; never two acks in one cycle.
//   4. p1 reads 0x13 (misaligned), then 0xFD (out of range) -> each gives p1_ack=1, p1_err=1, p1_rdata=0; mem_ren/mem_wen stay 0.
//   5. rst_n=0 during ISSUE of a p0 read -> next cycle all outputs are 0, no p0_ack; after release, a fresh p0 read completes normally.
//   6. p0_req held through ack for 3 reads of 0x00,0x04,0x08 -> acks 3 cycles apart, correct data each time.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
//   state_t   : FSM encoding (IDLE / ISSUE / RESP)
//   PORT_IF   : port 0, instruction fetch
//   PORT_LS   : port 1, load/store
//   is_legal  : word-aligned and inside the memory
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  // A request is legal when it is word aligned and the whole word lies
  // inside the memory (last legal word address is mem_bytes-4).
  function automatic logic is_legal(input logic [63:0] addr,
                                    input logic [63:0] mem_bytes);
    return (addr[1:0] == 2'b00) && (mem_bytes >= 64'd4) &&
           (addr <= (mem_bytes - 64'd4));
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, synchronous active-low reset
//   req[1:0]   : request lines
//   update     : commit the current grant into the last-grant flop
//   gnt[1:0]   : one-hot grant (zero when nobody requests)
// On a tie the port that was not granted last wins. After reset port 0
// is favoured.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // 1 = port 1 was granted last, so port 0 wins the next tie.
  logic last_q;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (update && (gnt != 2'b00)) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port, byte-addressed, word-wide memory between an
// instruction-fetch port (p0) and a load/store port (p1).
//   clk, rst_n            : clock, synchronous active-low reset
//   pN_req/we/addr/wdata  : request from port N, held stable until pN_ack
//   pN_rdata/ack/err      : completion; ack is a one-cycle pulse, err marks
//                           a misaligned or out-of-range request
//   mem_addr/wdata        : memory address and write data (hold last value)
//   mem_ren/mem_wen       : memory strobes, high for the single issue cycle
//   mem_rdata             : registered memory read data
//   dbg_state             : current FSM state
// Handshake: a port raises req with we/addr/wdata and keeps all of them
// stable until it sees ack; the arbiter looks at them only while IDLE. If
// req is still high in the ack cycle it is taken as a new request at the
// next edge. Every access, legal or not, takes exactly three cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ack,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ren,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  state_t state_q, state_d;

  logic [1:0]        gnt;
  logic              capture;   // IDLE and someone requests: latch winner
  logic              respond;   // RESP: memory data is valid, answer port
  logic              sel_ls;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_legal;

  logic              port_q;
  logic              we_q;
  logic              legal_q;
  logic [DATA_W-1:0] rsp_data;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({p1_req, p0_req}),
    .update (capture),
    .gnt    (gnt)
  );

  assign sel_ls    = gnt[1];
  assign sel_we    = sel_ls ? p1_we    : p0_we;
  assign sel_addr  = sel_ls ? p1_addr  : p0_addr;
  assign sel_wdata = sel_ls ? p1_wdata : p0_wdata;
  assign sel_legal = is_legal(64'(sel_addr), 64'(MEM_BYTES));

  // Writes and rejected requests answer with zero data.
  assign rsp_data  = (legal_q && !we_q) ? mem_rdata : '0;

  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    respond = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          capture = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        respond = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      port_q    <= PORT_IF;
      we_q      <= 1'b0;
      legal_q   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_ren   <= 1'b0;
      mem_wen   <= 1'b0;
      p0_rdata  <= '0;
      p0_ack    <= 1'b0;
      p0_err    <= 1'b0;
      p1_rdata  <= '0;
      p1_ack    <= 1'b0;
      p1_err    <= 1'b0;
    end else begin
      // Strobes and completion flags are single-cycle pulses.
      mem_ren <= 1'b0;
      mem_wen <= 1'b0;
      p0_ack  <= 1'b0;
      p0_err  <= 1'b0;
      p1_ack  <= 1'b0;
      p1_err  <= 1'b0;

      if (capture) begin
        port_q    <= sel_ls;
        we_q      <= sel_we;
        legal_q   <= sel_legal;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        // An illegal request walks the same path with both strobes low,
        // so the memory never sees it.
        mem_ren   <= sel_legal && !sel_we;
        mem_wen   <= sel_legal && sel_we;
      end

      if (respond) begin
        if (port_q == PORT_IF) begin
          p0_rdata <= rsp_data;
          p0_ack   <= 1'b1;
          p0_err   <= !legal_q;
        end else begin
          p1_rdata <= rsp_data;
          p1_ack   <= 1'b1;
          p1_err   <= !legal_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int MEM_BYTES = 256;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              p0_req, p0_we, p1_req, p1_we;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata;
  logic              p0_ack, p0_err, p1_ack, p1_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_ren, mem_wen;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_rdata  (p0_rdata),
    .p0_ack    (p0_ack),
    .p0_err    (p0_err),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_rdata  (p1_rdata),
    .p1_ack    (p1_ack),
    .p1_err    (p1_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // ---------------- check bookkeeping ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    else
      n_pass++;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
    else
      n_pass++;
  endtask

  // ---------------- memory behind the arbiter ----------------
  logic [7:0] ram [0:MEM_BYTES-1];
  logic [7:0] ram_a;

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) ram[i] = 8'(i);
    ram[16] = 8'hEF; ram[17] = 8'hBE; ram[18] = 8'hAD; ram[19] = 8'hDE;
    forever begin
      @(posedge clk);
      ram_a = mem_addr[7:0];
      mem_rdata <= mem_ren ? {ram[ram_a + 8'd3], ram[ram_a + 8'd2], ram[ram_a + 8'd1], ram[ram_a]}
                           : 32'hA5A5_A5A5;
      if (mem_wen) begin
        ram[ram_a]        = mem_wdata[7:0];
        ram[ram_a + 8'd1] = mem_wdata[15:8];
        ram[ram_a + 8'd2] = mem_wdata[23:16];
        ram[ram_a + 8'd3] = mem_wdata[31:24];
      end
    end
  end

  // ---------------- reference model (transaction level) ----------------
  // Each posedge: if the arbiter is free and someone requests, pick the
  // winner, perform the access on a private byte array and schedule the
  // completion two edges later. Outputs expected for the cycle that
  // follows this edge are left in e_*.
  int          cyc = 0;
  logic        model_on = 1'b0;
  logic [7:0]  ref_mem [0:MEM_BYTES-1];
  logic        e_rst, e_ren, e_wen, e_ack0, e_ack1, e_err0, e_err1;
  logic [31:0] e_addr, e_wdata, e_rd0, e_rd1;
  logic        pend, pend_port, pend_legal;
  int          pend_cyc;
  logic [31:0] pend_data;
  int          next_free;
  logic        last_ls;
  logic        hold0, hold1;
  logic        m_win, m_we, m_legal;
  logic [31:0] m_a, m_wd, m_data;
  int          m_i;

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'(i);
    ref_mem[16] = 8'hEF; ref_mem[17] = 8'hBE; ref_mem[18] = 8'hAD; ref_mem[19] = 8'hDE;
    hold0 = 1'b0; hold1 = 1'b0; pend = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      // A granted port must keep req high until its ack.
      if (model_on && rst_n) begin
        if (hold0) chk1("p0_req_held_until_ack", p0_req, 1'b1);
        if (hold1) chk1("p1_req_held_until_ack", p1_req, 1'b1);
      end
      if (!rst_n) begin
        model_on = 1'b1;
        e_rst = 1'b1;
        {e_ren, e_wen, e_ack0, e_ack1, e_err0, e_err1} = '0;
        e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
        pend = 1'b0; hold0 = 1'b0; hold1 = 1'b0;
        next_free = cyc + 1;
        last_ls = 1'b1;
      end else begin
        e_rst = 1'b0;
        {e_ren, e_wen, e_ack0, e_ack1, e_err0, e_err1} = '0;
        if (pend && pend_cyc == cyc) begin
          if (pend_port) begin
            e_ack1 = 1'b1; e_err1 = !pend_legal; e_rd1 = pend_data; hold1 = 1'b0;
          end else begin
            e_ack0 = 1'b1; e_err0 = !pend_legal; e_rd0 = pend_data; hold0 = 1'b0;
          end
          pend = 1'b0;
        end
        if (model_on && cyc >= next_free && (p0_req || p1_req)) begin
          m_win   = (p0_req && p1_req) ? !last_ls : p1_req;
          m_a     = m_win ? p1_addr  : p0_addr;
          m_wd    = m_win ? p1_wdata : p0_wdata;
          m_we    = m_win ? p1_we    : p0_we;
          m_legal = (m_a % 4 == 0) && (m_a <= MEM_BYTES - 4);
          e_addr  = m_a;
          e_wdata = m_wd;
          m_data  = '0;
          if (m_legal) begin
            m_i = int'(m_a);
            if (m_we) begin
              e_wen = 1'b1;
              for (int b = 0; b < 4; b++) ref_mem[m_i + b] = m_wd[8*b +: 8];
            end else begin
              e_ren  = 1'b1;
              m_data = {ref_mem[m_i + 3], ref_mem[m_i + 2], ref_mem[m_i + 1], ref_mem[m_i]};
            end
          end
          pend = 1'b1; pend_cyc = cyc + 2; pend_port = m_win;
          pend_legal = m_legal; pend_data = m_data;
          next_free = cyc + 3;
          last_ls = m_win;
          if (m_win) hold1 = 1'b1; else hold0 = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare + ack log ----------------
  logic        log_port [$];
  logic [31:0] log_data [$];
  logic        log_err  [$];
  int          log_cyc  [$];
  int          ren_cnt = 0;
  int          wen_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (model_on) begin
      chk1("mem_ren", mem_ren, e_ren);
      chk1("mem_wen", mem_wen, e_wen);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk1("p0_ack", p0_ack, e_ack0);
      chk1("p1_ack", p1_ack, e_ack1);
      chk1("p0_err", p0_err, e_err0);
      chk1("p1_err", p1_err, e_err1);
      if (e_ack0 || e_rst) chk("p0_rdata", p0_rdata, e_rd0);
      if (e_ack1 || e_rst) chk("p1_rdata", p1_rdata, e_rd1);
      chk1("acks_exclusive", p0_ack & p1_ack, 1'b0);
      chk1("strobes_exclusive", mem_ren & mem_wen, 1'b0);
      if (p0_ack) begin
        log_port.push_back(1'b0); log_data.push_back(p0_rdata);
        log_err.push_back(p0_err); log_cyc.push_back(cyc);
      end
      if (p1_ack) begin
        log_port.push_back(1'b1); log_data.push_back(p1_rdata);
        log_err.push_back(p1_err); log_cyc.push_back(cyc);
      end
      ren_cnt = ren_cnt + (mem_ren ? 1 : 0);
      wen_cnt = wen_cnt + (mem_wen ? 1 : 0);
    end
  end

  // ---------------- driver tasks ----------------
  int set_cyc;

  task automatic set_port(input logic port, input logic req, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end
  endtask

  // Issue cnt accesses at base, base+4, ... back to back, keeping req
  // high through each ack except the last.
  task automatic run_port(input logic port, input logic we, input logic [31:0] base,
                          input logic [31:0] wbase, input int cnt);
    logic got;
    @(negedge clk);
    set_port(port, 1'b1, we, base, wbase);
    set_cyc = cyc;
    for (int i = 0; i < cnt; i++) begin
      got = 1'b0;
      for (int t = 0; t < 30 && !got; t++) begin
        @(negedge clk);
        if (port ? p1_ack : p0_ack) got = 1'b1;
      end
      if (!got) begin
        chk1("ack_timeout", got, 1'b1);
        set_port(port, 1'b0, 1'b0, '0, '0);
        return;
      end
      if (i < cnt - 1)
        set_port(port, 1'b1, we, base + 32'(4 * (i + 1)), wbase + 32'(i + 1));
      else
        set_port(port, 1'b0, 1'b0, '0, '0);
    end
  endtask

  // ---------------- directed tests ----------------
  int n0, r0, w0;

  initial begin
    rst_n = 1'b0;
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk1("reset_p0_ack", p0_ack, 1'b0);
    chk("reset_state_idle", 32'(dbg_state), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: p0 read of preloaded word
    n0 = log_port.size(); r0 = ren_cnt;
    run_port(1'b0, 1'b0, 32'h10, 32'h0, 1);
    @(negedge clk);
    chk("t1_ack_count", 32'(log_port.size() - n0), 32'd1);
    if (log_port.size() > n0) begin
      chk1("t1_port", log_port[n0], 1'b0);
      chk("t1_rdata", log_data[n0], 32'hDEADBEEF);
      chk("t1_latency", 32'(log_cyc[n0] - set_cyc), 32'd3);
    end
    chk("t1_ren_cycles", 32'(ren_cnt - r0), 32'd1);

    // 2: p1 write then p0 read back
    n0 = log_port.size();
    run_port(1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 1);
    run_port(1'b0, 1'b0, 32'h20, 32'h0, 1);
    @(negedge clk);
    chk("t2_ram", {ram[35], ram[34], ram[33], ram[32]}, 32'hCAFEF00D);
    chk("t2_ram_byte0", 32'(ram[32]), 32'h0D);
    if (log_port.size() > n0 + 1) chk("t2_rdata", log_data[n0 + 1], 32'hCAFEF00D);

    // 4: illegal p1 requests (misaligned, out of range)
    n0 = log_port.size(); r0 = ren_cnt; w0 = wen_cnt;
    run_port(1'b1, 1'b0, 32'h13, 32'h0, 1);
    run_port(1'b1, 1'b0, 32'hFD, 32'h0, 1);
    @(negedge clk);
    chk("t4_ack_count", 32'(log_port.size() - n0), 32'd2);
    for (int k = n0; k < log_port.size(); k++) begin
      chk1("t4_port", log_port[k], 1'b1);
      chk1("t4_err", log_err[k], 1'b1);
      chk("t4_rdata", log_data[k], 32'h0);
    end
    chk("t4_no_strobes", 32'(ren_cnt - r0 + wen_cnt - w0), 32'd0);

    // 3: both ports hold req for two accesses each -> alternate p0,p1,p0,p1
    n0 = log_port.size();
    fork
      run_port(1'b0, 1'b0, 32'h40, 32'h0, 2);
      run_port(1'b1, 1'b1, 32'h80, 32'h12340000, 2);
    join
    @(negedge clk);
    chk("t3_ack_count", 32'(log_port.size() - n0), 32'd4);
    if (log_port.size() >= n0 + 4) begin
      chk("t3_order", {28'h0, log_port[n0], log_port[n0+1], log_port[n0+2], log_port[n0+3]}, 32'b0101);
      chk("t3_p0_rdata_a", log_data[n0], 32'h43424140);
      chk("t3_p0_rdata_b", log_data[n0 + 2], 32'h47464544);
    end

    // 5: reset during ISSUE of a p0 read
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk1("t5_p0_ack", p0_ack, 1'b0);
    chk1("t5_mem_ren", mem_ren, 1'b0);
    chk("t5_mem_addr", mem_addr, 32'h0);
    chk("t5_p0_rdata", p0_rdata, 32'h0);
    chk("t5_state_idle", 32'(dbg_state), 32'h0);
    n0 = log_port.size();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_no_late_ack", 32'(log_port.size() - n0), 32'd0);
    run_port(1'b0, 1'b0, 32'h10, 32'h0, 1);
    @(negedge clk);
    if (log_port.size() > n0) chk("t5_fresh_rdata", log_data[n0], 32'hDEADBEEF);

    // 6: p0 keeps req high through ack for three sequential reads
    n0 = log_port.size();
    run_port(1'b0, 1'b0, 32'h00, 32'h0, 3);
    @(negedge clk);
    chk("t6_ack_count", 32'(log_port.size() - n0), 32'd3);
    if (log_port.size() >= n0 + 3) begin
      chk("t6_rdata0", log_data[n0],     32'h03020100);
      chk("t6_rdata1", log_data[n0 + 1], 32'h07060504);
      chk("t6_rdata2", log_data[n0 + 2], 32'h0B0A0908);
      chk("t6_spacing_a", 32'(log_cyc[n0 + 1] - log_cyc[n0]), 32'd3);
      chk("t6_spacing_b", 32'(log_cyc[n0 + 2] - log_cyc[n0 + 1]), 32'd3);
    end

    // final memory image against the model's copy
    repeat (2) @(negedge clk);
    begin
      int mism;
      mism = 0;
      for (int i = 0; i < MEM_BYTES; i++) if (ram[i] !== ref_mem[i]) mism++;
      chk("ram_image_mismatches", 32'(mism), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
